cipher_csr_gen: RTL and testbench

Parametrised CSR front-end for the block-cipher cores (IBR128, Blowfish-128 and wider successors). It holds IV, key and plaintext words, drives the core's mode controls, and runs a start/done handshake FSM. It captures ciphertext on completion, aborts a run on timeout or software request, and raises a maskable interrupt. Sits between the 32-bit bus slave decode (CS/Write/Read/Addr) and the cipher core.

---
 rtl/cipher_csr_pkg.sv | 39 +++
 rtl/cipher_csr_if.sv | 44 ++++
 rtl/cipher_csr_fsm.sv | 84 ++++++++
 rtl/cipher_csr_gen.sv | 151 +++++++++++++++
 tb/tb_cipher_csr_gen.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cipher_csr_pkg.sv
`default_nettype none
//==============================================================================
// cipher_csr_pkg: register map, bit indices and FSM states for cipher_csr_gen
// Rev 1.0
//==============================================================================
package cipher_csr_pkg;

  localparam logic [5:0] c_addr_iv       = 6'h00;
  localparam logic [5:0] c_addr_key      = 6'h08;
  localparam logic [5:0] c_addr_pt       = 6'h10;
  localparam logic [5:0] c_addr_ct       = 6'h18;
  localparam logic [5:0] c_addr_ctrl     = 6'h20;
  localparam logic [5:0] c_addr_sta      = 6'h21;
  localparam logic [5:0] c_addr_irq_en   = 6'h22;
  localparam logic [5:0] c_addr_irq_stat = 6'h23;
  localparam logic [5:0] c_addr_timeout  = 6'h24;

  localparam int c_ctrl_en    = 0;
  localparam int c_ctrl_sa    = 1;
  localparam int c_ctrl_enc   = 2;
  localparam int c_ctrl_fb    = 5;
  localparam int c_ctrl_go    = 8;
  localparam int c_ctrl_abort = 9;

  localparam int c_irq_done  = 0;
  localparam int c_irq_toerr = 1;
  localparam int c_irq_werr  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic bit width_ok(input int w);
    return ((w % 32) == 0) && (w >= 64) && (w <= 256);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cipher_csr_if.sv
`default_nettype none
//==============================================================================
// cipher_csr_if: bus-decode and cipher-core signals of the CSR front-end
// Rev 1.0
//==============================================================================
interface cipher_csr_if #(
  parameter int BLK_W  = 128,
  parameter int KEY_W  = 128,
  parameter int ADDR_W = 6
);
  logic              CS;
  logic              Write;
  logic              Read;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       WData;
  logic [31:0]       RData;
  logic              Irq;
  logic              Enable;
  logic              SA;
  logic              Encrypt;
  logic              FB;
  logic [1:0]        SOM;
  logic              Start;
  logic              Abort;
  logic              Busy;
  logic [BLK_W-1:0]  plainText;
  logic [BLK_W-1:0]  IV;
  logic [KEY_W-1:0]  key;
  logic [BLK_W-1:0]  cipherText;
  logic              Done;

  modport slave (
    input  CS, Write, Read, Addr, WData, cipherText, Done,
    output RData, Irq, Enable, SA, Encrypt, FB, SOM, Start, Abort, Busy,
           plainText, IV, key
  );

  modport master (
    output CS, Write, Read, Addr, WData, cipherText, Done,
    input  RData, Irq, Enable, SA, Encrypt, FB, SOM, Start, Abort, Busy,
           plainText, IV, key
  );
endinterface
`default_nettype wire

// File: rtl/cipher_csr_fsm.sv
`default_nettype none
//==============================================================================
// cipher_csr_fsm: start/done handshake, timeout counter, Start/Abort pulses
// Rev 1.0
//==============================================================================
module cipher_csr_fsm
  import cipher_csr_pkg::*;
#(
  parameter int TO_W = 16
) (
  input  logic            Clk,
  input  logic            RstN,
  input  logic            i_go,
  input  logic            i_abort_req,
  input  logic            i_done,
  input  logic [TO_W-1:0] i_timeout,
  output logic            o_start,
  output logic            o_abort,
  output logic            o_busy,
  output logic            o_done_evt,
  output logic            o_to_evt
);

  state_t          r_state, w_state_nxt;
  logic [TO_W-1:0] r_cnt, w_cnt_nxt;
  logic            r_start, w_start_nxt;
  logic            r_abort, w_abort_nxt;

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_start <= w_start_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  // In RUN: core completion beats timeout, timeout beats software abort.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start_nxt = 1'b0;
    w_abort_nxt = 1'b0;
    o_done_evt  = 1'b0;
    o_to_evt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_go) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_start_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt != {TO_W{1'b1}}) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (i_done) begin
          o_done_evt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if ((i_timeout != '0) && (r_cnt == i_timeout)) begin
          o_to_evt    = 1'b1;
          w_abort_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (i_abort_req) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_start = r_start;
  assign o_abort = r_abort;
  assign o_busy  = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: rtl/cipher_csr_gen.sv
`default_nettype none
//==============================================================================
// cipher_csr_gen: CSR register file and read mux in front of a block-cipher core
// Rev 1.0
//==============================================================================
module cipher_csr_gen
  import cipher_csr_pkg::*;
#(
  parameter int BLK_W  = 128,
  parameter int KEY_W  = 128,
  parameter int ADDR_W = 6,
  parameter int TO_W   = 16
) (
  input  logic         Clk,
  input  logic         RstN,
  cipher_csr_if.slave  bus
);

  localparam int         NB   = BLK_W / 32;
  localparam int         NK   = KEY_W / 32;
  localparam logic [3:0] c_nb = 4'(NB);
  localparam logic [3:0] c_nk = 4'(NK);

  if (!width_ok(BLK_W)) begin : g_chk_blk_w
    $error("BLK_W must be a multiple of 32 in 64..256");
  end
  if (!width_ok(KEY_W)) begin : g_chk_key_w
    $error("KEY_W must be a multiple of 32 in 64..256");
  end
  if (ADDR_W != 6) begin : g_chk_addr_w
    $error("ADDR_W must be 6 for this register map");
  end
  if ((TO_W < 1) || (TO_W > 32)) begin : g_chk_to_w
    $error("TO_W must be in 1..32");
  end

  logic [NB-1:0][31:0] r_iv, r_pt, r_ct;
  logic [NK-1:0][31:0] r_key;
  logic [5:0]          r_ctrl;
  logic [2:0]          r_irq_en, r_irq_stat;
  logic [TO_W-1:0]     r_timeout;
  logic [31:0]         r_rdata;

  logic        w_wr, w_rd, w_busy;
  logic [2:0]  w_idx;
  logic        w_iv_hit, w_key_hit, w_pt_hit, w_ct_hit, w_ctrl_wr;
  logic        w_go, w_abort_req, w_locked_wr, w_done_evt, w_to_evt;
  logic [2:0]  w_stat_set, w_stat_clr;
  logic [31:0] w_sta, w_rmux;

  assign w_wr      = bus.CS & bus.Write;
  assign w_rd      = bus.CS & bus.Read;
  assign w_idx     = bus.Addr[2:0];
  assign w_iv_hit  = (bus.Addr[5:3] == 3'd0) && ({1'b0, w_idx} < c_nb);
  assign w_key_hit = (bus.Addr[5:3] == 3'd1) && ({1'b0, w_idx} < c_nk);
  assign w_pt_hit  = (bus.Addr[5:3] == 3'd2) && ({1'b0, w_idx} < c_nb);
  assign w_ct_hit  = (bus.Addr[5:3] == 3'd3) && ({1'b0, w_idx} < c_nb);
  assign w_ctrl_wr = w_wr && (bus.Addr == c_addr_ctrl);

  // ABORT in the same write as GO cancels the launch.
  assign w_go        = w_ctrl_wr && !w_busy && bus.WData[c_ctrl_go]
                       && bus.WData[c_ctrl_en] && !bus.WData[c_ctrl_abort];
  assign w_abort_req = w_ctrl_wr && w_busy && bus.WData[c_ctrl_abort];
  assign w_locked_wr = w_busy && w_wr
                       && (w_iv_hit || w_key_hit || w_pt_hit || (bus.Addr == c_addr_ctrl));

  assign w_stat_set = {w_locked_wr, w_to_evt, w_done_evt};
  assign w_stat_clr = (w_wr && (bus.Addr == c_addr_irq_stat)) ? bus.WData[2:0] : 3'b000;

  cipher_csr_fsm #(.TO_W(TO_W)) u_fsm (
    .Clk         (Clk),
    .RstN        (RstN),
    .i_go        (w_go),
    .i_abort_req (w_abort_req),
    .i_done      (bus.Done),
    .i_timeout   (r_timeout),
    .o_start     (bus.Start),
    .o_abort     (bus.Abort),
    .o_busy      (w_busy),
    .o_done_evt  (w_done_evt),
    .o_to_evt    (w_to_evt)
  );

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      r_iv       <= '0;
      r_pt       <= '0;
      r_ct       <= '0;
      r_key      <= '0;
      r_ctrl     <= '0;
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_timeout  <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_wr && !w_busy) begin
        for (int i = 0; i < NB; i++) begin
          if (w_iv_hit && (w_idx == 3'(i))) r_iv[i] <= bus.WData;
          if (w_pt_hit && (w_idx == 3'(i))) r_pt[i] <= bus.WData;
        end
        for (int i = 0; i < NK; i++) begin
          if (w_key_hit && (w_idx == 3'(i))) r_key[i] <= bus.WData;
        end
        if (bus.Addr == c_addr_ctrl) r_ctrl <= bus.WData[5:0];
      end
      if (w_wr && (bus.Addr == c_addr_irq_en))  r_irq_en  <= bus.WData[2:0];
      if (w_wr && (bus.Addr == c_addr_timeout)) r_timeout <= bus.WData[TO_W-1:0];
      // Hardware events win over a simultaneous write-1-to-clear.
      r_irq_stat <= w_stat_set | (r_irq_stat & ~w_stat_clr);
      if (w_done_evt) r_ct <= bus.cipherText;
      if (w_rd) r_rdata <= w_rmux;
    end
  end

  assign w_sta = {22'h0, r_irq_stat[c_irq_werr], r_irq_stat[c_irq_toerr], 2'b00,
                  r_ctrl[5:1], r_irq_stat[c_irq_done]};

  always_comb begin
    w_rmux = '0;
    for (int i = 0; i < NB; i++) begin
      if (w_iv_hit && (w_idx == 3'(i))) w_rmux = r_iv[i];
      if (w_pt_hit && (w_idx == 3'(i))) w_rmux = r_pt[i];
      if (w_ct_hit && (w_idx == 3'(i))) w_rmux = r_ct[i];
    end
    for (int i = 0; i < NK; i++) begin
      if (w_key_hit && (w_idx == 3'(i))) w_rmux = r_key[i];
    end
    case (bus.Addr)
      c_addr_ctrl:     w_rmux = {26'h0, r_ctrl};
      c_addr_sta:      w_rmux = w_sta;
      c_addr_irq_en:   w_rmux = {29'h0, r_irq_en};
      c_addr_irq_stat: w_rmux = {29'h0, r_irq_stat};
      c_addr_timeout:  w_rmux = 32'(r_timeout);
      default:         ;
    endcase
  end

  assign bus.RData     = r_rdata;
  assign bus.Irq       = |(r_irq_stat & r_irq_en);
  assign bus.Enable    = r_ctrl[c_ctrl_en];
  assign bus.SA        = r_ctrl[c_ctrl_sa];
  assign bus.Encrypt   = r_ctrl[c_ctrl_enc];
  assign bus.SOM       = r_ctrl[4:3];
  assign bus.FB        = r_ctrl[c_ctrl_fb];
  assign bus.Busy      = w_busy;
  assign bus.plainText = r_pt;
  assign bus.IV        = r_iv;
  assign bus.key       = r_key;

endmodule
`default_nettype wire

// File: tb/tb_cipher_csr_gen.sv
`default_nettype none
//==============================================================================
// tb_cipher_csr_gen: directed vectors for cipher_csr_gen (128-bit and 256-bit)
// Rev 1.0
//==============================================================================
module tb_cipher_csr_gen;

  logic Clk = 1'b0;
  logic RstN;
  always #5 Clk = ~Clk;

  cipher_csr_if #(.BLK_W(128), .KEY_W(128), .ADDR_W(6)) ma ();
  cipher_csr_if #(.BLK_W(256), .KEY_W(256), .ADDR_W(6)) mb ();

  cipher_csr_gen #(.BLK_W(128), .KEY_W(128), .ADDR_W(6), .TO_W(16)) u_dut_a (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (ma.slave)
  );

  cipher_csr_gen #(.BLK_W(256), .KEY_W(256), .ADDR_W(6), .TO_W(16)) u_dut_b (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (mb.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_a(input logic [5:0] a, input logic [31:0] d);
    @(negedge Clk);
    ma.CS = 1'b1; ma.Write = 1'b1; ma.Addr = a; ma.WData = d;
    @(negedge Clk);
    ma.CS = 1'b0; ma.Write = 1'b0;
  endtask

  task automatic rd_a(input logic [5:0] a, output logic [31:0] d);
    @(negedge Clk);
    ma.CS = 1'b1; ma.Read = 1'b1; ma.Addr = a;
    @(negedge Clk);
    ma.CS = 1'b0; ma.Read = 1'b0;
    d = ma.RData;
  endtask

  task automatic wr_b(input logic [5:0] a, input logic [31:0] d);
    @(negedge Clk);
    mb.CS = 1'b1; mb.Write = 1'b1; mb.Addr = a; mb.WData = d;
    @(negedge Clk);
    mb.CS = 1'b0; mb.Write = 1'b0;
  endtask

  task automatic rd_b(input logic [5:0] a, output logic [31:0] d);
    @(negedge Clk);
    mb.CS = 1'b1; mb.Read = 1'b1; mb.Addr = a;
    @(negedge Clk);
    mb.CS = 1'b0; mb.Read = 1'b0;
    d = mb.RData;
  endtask

  task automatic pulse_reset();
    @(negedge Clk); RstN = 1'b0;
    @(negedge Clk); RstN = 1'b1;
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{6'h08, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[1]  = '{6'h03, 32'h13572468, 32'h13572468};
    vecs[2]  = '{6'h12, 32'h0BADF00D, 32'h0BADF00D};
    vecs[3]  = '{6'h04, 32'hFFFFFFFF, 32'h00000000};
    vecs[4]  = '{6'h0C, 32'h12345678, 32'h00000000};
    vecs[5]  = '{6'h19, 32'hFFFFFFFF, 32'h00000000};
    vecs[6]  = '{6'h20, 32'h0000003E, 32'h0000003E};
    vecs[7]  = '{6'h21, 32'hFFFFFFFF, 32'h0000003E};
    vecs[8]  = '{6'h22, 32'hFFFFFFFF, 32'h00000007};
    vecs[9]  = '{6'h23, 32'hFFFFFFFF, 32'h00000000};
    vecs[10] = '{6'h24, 32'hABCD1234, 32'h00001234};
    vecs[11] = '{6'h25, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{6'h3F, 32'hFFFFFFFF, 32'h00000000};
    vecs[13] = '{6'h20, 32'h0000023E, 32'h0000003E};

    RstN = 1'b0;
    ma.CS = 1'b0; ma.Write = 1'b0; ma.Read = 1'b0; ma.Addr = '0; ma.WData = '0;
    ma.Done = 1'b0; ma.cipherText = '0;
    mb.CS = 1'b0; mb.Write = 1'b0; mb.Read = 1'b0; mb.Addr = '0; mb.WData = '0;
    mb.Done = 1'b0; mb.cipherText = '0;
    repeat (3) @(negedge Clk);
    RstN = 1'b1;

    // Reset state
    chk1("rst_busy", ma.Busy, 1'b0);
    chk1("rst_start", ma.Start, 1'b0);
    chk1("rst_abort", ma.Abort, 1'b0);
    chk1("rst_irq", ma.Irq, 1'b0);
    chk32("rst_rdata", ma.RData, 32'h0);
    rd_a(6'h21, rd);
    chk32("rst_sta", rd, 32'h0);

    // Register map write/readback in IDLE
    for (int i = 0; i < 14; i++) begin
      wr_a(vecs[i].addr, vecs[i].wdata);
      rd_a(vecs[i].addr, rd);
      chk32($sformatf("map_%02h_v%0d", vecs[i].addr, i), rd, vecs[i].rexp);
    end
    chk32("ctrl_som", 32'(ma.SOM), 32'h3);
    chk1("ctrl_fb", ma.FB, 1'b1);
    chk1("ctrl_enable", ma.Enable, 1'b0);
    chk1("map_irq_idle", ma.Irq, 1'b0);

    // Normal run with Done
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      wr_a(6'(8 + i), 32'h11111111 * (i + 1));
      wr_a(6'(16 + i), 32'hA0000000 + i);
      wr_a(6'(i), 32'hB0000000 + i);
    end
    chkw("key_out", 256'(ma.key), 256'h44444444_33333333_22222222_11111111);
    chkw("pt_out", 256'(ma.plainText), 256'hA0000003_A0000002_A0000001_A0000000);
    chkw("iv_out", 256'(ma.IV), 256'hB0000003_B0000002_B0000001_B0000000);
    wr_a(6'h20, 32'h105);
    chk1("go_start", ma.Start, 1'b1);
    chk1("go_busy", ma.Busy, 1'b1);
    chk1("go_enc", ma.Encrypt, 1'b1);
    @(negedge Clk);
    chk1("go_start_once", ma.Start, 1'b0);
    ma.Done = 1'b1; ma.cipherText = {4{32'hA5A5A5A5}};
    @(negedge Clk);
    ma.Done = 1'b0;
    chk1("done_idle", ma.Busy, 1'b0);
    chk1("done_no_abort", ma.Abort, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd_a(6'(24 + i), rd);
      chk32($sformatf("ct%0d", i), rd, 32'hA5A5A5A5);
    end
    rd_a(6'h21, rd);
    chk32("done_sta", rd, 32'h005);
    chk1("done_irq_masked", ma.Irq, 1'b0);
    wr_a(6'h22, 32'h1);
    chk1("done_irq_en", ma.Irq, 1'b1);
    wr_a(6'h23, 32'h1);
    chk1("done_irq_w1c", ma.Irq, 1'b0);

    // Wide build: CT7 at 0x1F
    wr_b(6'h20, 32'h105);
    chk1("b_start", mb.Start, 1'b1);
    @(negedge Clk);
    mb.Done = 1'b1;
    mb.cipherText = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    @(negedge Clk);
    mb.Done = 1'b0;
    rd_b(6'h1F, rd);
    chk32("b_ct7", rd, 32'h88888888);
    rd_b(6'h1C, rd);
    chk32("b_ct4", rd, 32'h55555555);

    // Timeout: TIMEOUT=5, Busy for 6 cycles, Abort in the 7th
    wr_a(6'h24, 32'h5);
    wr_a(6'h20, 32'h105);
    chk1("to_start", ma.Start, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      chk1($sformatf("to_busy_c%0d", k), ma.Busy, (k <= 6));
      chk1($sformatf("to_abort_c%0d", k), ma.Abort, (k == 7));
      if (k < 7) @(negedge Clk);
    end
    rd_a(6'h21, rd);
    chk32("to_sta", rd, 32'h104);
    chk1("to_irq_masked", ma.Irq, 1'b0);
    rd_a(6'h18, rd);
    chk32("to_ct_kept", rd, 32'hA5A5A5A5);
    wr_a(6'h23, 32'h2);
    rd_a(6'h21, rd);
    chk32("to_sta_clr", rd, 32'h004);

    // Write lock during RUN, then software abort
    wr_a(6'h24, 32'h0);
    wr_a(6'h20, 32'h105);
    wr_a(6'h10, 32'hDEADBEEF);
    chk32("lock_pt0", ma.plainText[31:0], 32'hA0000000);
    rd_a(6'h21, rd);
    chk32("lock_sta", rd, 32'h204);
    chk1("lock_busy", ma.Busy, 1'b1);
    wr_a(6'h20, 32'h200);
    chk1("sw_abort", ma.Abort, 1'b1);
    chk1("sw_abort_idle", ma.Busy, 1'b0);
    chk1("sw_abort_nostart", ma.Start, 1'b0);
    @(negedge Clk);
    chk1("sw_abort_once", ma.Abort, 1'b0);
    chk1("sw_abort_enable", ma.Enable, 1'b1);
    wr_a(6'h23, 32'h4);

    // Done coincides with timeout and with a W1C of DONE
    wr_a(6'h24, 32'h3);
    wr_a(6'h20, 32'h105);
    repeat (3) @(negedge Clk);
    ma.Done = 1'b1;
    ma.cipherText = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    ma.CS = 1'b1; ma.Write = 1'b1; ma.Addr = 6'h23; ma.WData = 32'h1;
    @(negedge Clk);
    ma.Done = 1'b0; ma.CS = 1'b0; ma.Write = 1'b0;
    chk1("race_busy", ma.Busy, 1'b0);
    chk1("race_no_abort", ma.Abort, 1'b0);
    chk1("race_irq", ma.Irq, 1'b1);
    rd_a(6'h21, rd);
    chk32("race_sta", rd, 32'h005);
    rd_a(6'h18, rd);
    chk32("race_ct0", rd, 32'h76543210);
    wr_a(6'h23, 32'h1);

    // GO+ABORT together and GO without Enable: no launch
    wr_a(6'h20, 32'h301);
    chk1("goab_start", ma.Start, 1'b0);
    chk1("goab_busy", ma.Busy, 1'b0);
    wr_a(6'h20, 32'h100);
    chk1("go_noen_start", ma.Start, 1'b0);
    chk1("go_noen_busy", ma.Busy, 1'b0);

    // Reset during RUN
    wr_a(6'h24, 32'h0);
    wr_a(6'h20, 32'h105);
    chk1("mid_busy", ma.Busy, 1'b1);
    @(negedge Clk);
    RstN = 1'b0;
    @(negedge Clk);
    chk1("mid_rst_busy", ma.Busy, 1'b0);
    chk1("mid_rst_abort", ma.Abort, 1'b0);
    RstN = 1'b1;
    chkw("mid_rst_key", 256'(ma.key), 256'h0);
    rd_a(6'h21, rd);
    chk32("mid_rst_sta", rd, 32'h0);
    rd_a(6'h18, rd);
    chk32("mid_rst_ct0", rd, 32'h0);
    rd_a(6'h08, rd);
    chk32("mid_rst_key0", rd, 32'h0);
    rd_a(6'h22, rd);
    chk32("mid_rst_irqen", rd, 32'h0);
    chk1("mid_rst_abort2", ma.Abort, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
